// File: rtl/ex_stage.sv
// Execute stage of the RV64 pipeline: ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative 64-cycle shift-add multiplier with its stall logic.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        idexAluSRC,
    input  logic        idexBranch,
    input  logic        idexMemWrite,
    input  logic        idexMemRead,
    input  logic        idexMemToReg,
    input  logic        idexRegWrite,
    input  logic [4:0]  idexWrReg,
    input  logic [63:0] idexPc,
    input  logic [63:0] idexReg1,
    input  logic [63:0] idexReg2,
    input  logic [63:0] idexInme,
    input  logic [1:0]  idexAluOp,
    input  logic [2:0]  idexFun3,
    input  logic [6:0]  idexFun7,
    output logic        stall,
    output logic [63:0] exmemAluRes,
    output logic [63:0] exmemReg2,
    output logic [63:0] exmemBrTarget,
    output logic        exmemBrTaken,
    output logic        exmemMemWrite,
    output logic        exmemMemRead,
    output logic        exmemMemToReg,
    output logic        exmemRegWrite,
    output logic [4:0]  exmemWrReg
);
    logic [63:0] op_a, op_b, sum, diff, alu_res, ex_res;
    logic [5:0]  shamt;
    logic        is_alt;

    assign op_a   = idexReg1;
    assign op_b   = idexAluSRC ? idexInme : idexReg2;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign shamt  = op_b[5:0];
    assign is_alt = (idexFun7 == 7'b0100000);

    always_comb begin
        alu_res = sum;
        case (idexAluOp)
            2'b00: alu_res = sum;
            2'b01: alu_res = diff;
            2'b10: begin
                case (idexFun3)
                    3'b000: alu_res = is_alt ? diff : sum;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {63'd0, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_res = {63'd0, op_a < op_b};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: alu_res = is_alt ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
                    3'b110: alu_res = op_a | op_b;
                    3'b111: alu_res = op_a & op_b;
                    default: alu_res = sum;
                endcase
            end
            default: alu_res = sum;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    mul_state_e  state_q, state_d;
    logic [63:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_mul;

    assign is_mul = (idexAluOp == 2'b10) && (idexFun3 == 3'b000) && (idexFun7 == 7'b0000001);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Operands are captured once in IDLE; BUSY never looks at ID/EX again.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    state_d  = ST_BUSY;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall  = is_mul && (state_q != ST_DONE);
        ex_res = (is_mul && (state_q == ST_DONE)) ? acc_q : alu_res;
    end
`else
    assign stall  = 1'b0;
    assign ex_res = alu_res;
`endif

    logic [63:0] alu_res_d, alu_res_q, reg2_d, reg2_q, br_target_d, br_target_q;
    logic        br_taken_d, br_taken_q, mem_write_d, mem_write_q, mem_read_d, mem_read_q;
    logic        mem_to_reg_d, mem_to_reg_q, reg_write_d, reg_write_q;
    logic [4:0]  wr_reg_d, wr_reg_q;

    // A stalled edge loads a bubble: controls cleared, data held.
    always_comb begin
        alu_res_d    = alu_res_q;
        reg2_d       = reg2_q;
        br_target_d  = br_target_q;
        wr_reg_d     = wr_reg_q;
        br_taken_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        if (!stall) begin
            alu_res_d    = ex_res;
            reg2_d       = idexReg2;
            br_target_d  = idexPc + idexInme;
            wr_reg_d     = idexWrReg;
            br_taken_d   = idexBranch && (diff == 64'd0);
            mem_write_d  = idexMemWrite;
            mem_read_d   = idexMemRead;
            mem_to_reg_d = idexMemToReg;
            reg_write_d  = idexRegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_res_q    <= '0;
            reg2_q       <= '0;
            br_target_q  <= '0;
            wr_reg_q     <= '0;
            br_taken_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            alu_res_q    <= alu_res_d;
            reg2_q       <= reg2_d;
            br_target_q  <= br_target_d;
            wr_reg_q     <= wr_reg_d;
            br_taken_q   <= br_taken_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign exmemAluRes   = alu_res_q;
    assign exmemReg2     = reg2_q;
    assign exmemBrTarget = br_target_q;
    assign exmemWrReg    = wr_reg_q;
    assign exmemBrTaken  = br_taken_q;
    assign exmemMemWrite = mem_write_q;
    assign exmemMemRead  = mem_read_q;
    assign exmemMemToReg = mem_to_reg_q;
    assign exmemRegWrite = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver pushes one expected EX/MEM snapshot per clock edge,
// a monitor pops and compares after each edge. Works with or without EX_MUL_EN.
module tb_ex_stage;
  localparam int W = 205;

  typedef struct packed {
    logic        alusrc;
    logic        branch;
    logic        mw;
    logic        mr;
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] pc;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] imm;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } instr_t;

`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        idexAluSRC, idexBranch, idexMemWrite, idexMemRead, idexMemToReg, idexRegWrite;
  logic [4:0]  idexWrReg;
  logic [63:0] idexPc, idexReg1, idexReg2, idexInme;
  logic [1:0]  idexAluOp;
  logic [2:0]  idexFun3;
  logic [6:0]  idexFun7;
  logic        stall;
  logic [63:0] exmemAluRes, exmemReg2, exmemBrTarget;
  logic        exmemBrTaken, exmemMemWrite, exmemMemRead, exmemMemToReg, exmemRegWrite;
  logic [4:0]  exmemWrReg;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .idexAluSRC(idexAluSRC), .idexBranch(idexBranch), .idexMemWrite(idexMemWrite),
    .idexMemRead(idexMemRead), .idexMemToReg(idexMemToReg), .idexRegWrite(idexRegWrite),
    .idexWrReg(idexWrReg), .idexPc(idexPc), .idexReg1(idexReg1), .idexReg2(idexReg2),
    .idexInme(idexInme), .idexAluOp(idexAluOp), .idexFun3(idexFun3), .idexFun7(idexFun7),
    .stall(stall), .exmemAluRes(exmemAluRes), .exmemReg2(exmemReg2),
    .exmemBrTarget(exmemBrTarget), .exmemBrTaken(exmemBrTaken),
    .exmemMemWrite(exmemMemWrite), .exmemMemRead(exmemMemRead),
    .exmemMemToReg(exmemMemToReg), .exmemRegWrite(exmemRegWrite), .exmemWrReg(exmemWrReg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [63:0] last_alu, last_reg2, last_tgt;

  // ---------------- reference model ----------------
  function automatic bit is_mul(input instr_t t);
    return (t.aluop == 2'b10) && (t.f3 == 3'b000) && (t.f7 == 7'b0000001);
  endfunction

  function automatic logic [63:0] opb(input instr_t t);
    return t.alusrc ? t.imm : t.r2;
  endfunction

  function automatic logic [63:0] ref_alu(input instr_t t);
    logic [63:0] a, b, fill;
    int sh;
    a = t.r1;
    b = opb(t);
    sh = int'(b[5:0]);
    if (t.aluop == 2'b00) return a + b;
    if (t.aluop == 2'b01) return a - b;
    case (t.f3)
      3'b000: begin
        if (t.f7 == 7'b0100000) return a - b;
        if (MUL_EN && t.f7 == 7'b0000001) return a * b;
        return a + b;
      end
      3'b111: return a & b;
      3'b110: return a | b;
      3'b100: return a ^ b;
      3'b001: return a << sh;
      3'b101: begin
        fill = (t.f7 == 7'b0100000 && a[63]) ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0;
        return (a >> sh) | fill;
      end
      3'b010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input instr_t t);
    idexAluSRC = t.alusrc; idexBranch = t.branch; idexMemWrite = t.mw; idexMemRead = t.mr;
    idexMemToReg = t.m2r; idexRegWrite = t.rw; idexWrReg = t.wr; idexPc = t.pc;
    idexReg1 = t.r1; idexReg2 = t.r2; idexInme = t.imm;
    idexAluOp = t.aluop; idexFun3 = t.f3; idexFun7 = t.f7;
  endtask

  task automatic push_entry(input logic stall_chk, input logic stall_exp, input logic wr_chk,
                            input logic [4:0] wr, input logic rw, input logic m2r, input logic mr,
                            input logic mw, input logic taken, input logic [63:0] tgt,
                            input logic [63:0] reg2, input logic [63:0] alu);
    exp_q.push_back({stall_chk, stall_exp, wr_chk, wr, rw, m2r, mr, mw, taken, tgt, reg2, alu});
  endtask

  task automatic push_bubble();
    push_entry(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_tgt, last_reg2, last_alu);
  endtask

  task automatic push_result(input instr_t t, input logic [63:0] res);
    logic taken;
    taken = t.branch && ((t.r1 - opb(t)) == 64'd0);
    last_alu = res;
    last_reg2 = t.r2;
    last_tgt = t.pc + t.imm;
    push_entry(1'b1, 1'b0, 1'b1, t.wr, t.rw, t.m2r, t.mr, t.mw, taken, last_tgt, last_reg2, last_alu);
  endtask

  // A MUL holds its inputs for 65 stalled cycles and completes in the 66th.
  task automatic issue_with(input instr_t t, input logic [63:0] res);
    drive(t);
    if (MUL_EN && is_mul(t)) begin
      for (int i = 0; i < 65; i++) begin
        push_bubble();
        next_cycle();
      end
    end
    push_result(t, res);
    next_cycle();
  endtask

  task automatic issue(input instr_t t);
    issue_with(t, ref_alu(t));
  endtask

  function automatic instr_t rand_instr(input bit allow_mul);
    instr_t t;
    t.alusrc = 1'($urandom_range(0, 1));
    t.branch = 1'($urandom_range(0, 1));
    t.mw = 1'($urandom_range(0, 1));
    t.mr = 1'($urandom_range(0, 1));
    t.m2r = 1'($urandom_range(0, 1));
    t.rw = 1'($urandom_range(0, 1));
    t.wr = 5'($urandom_range(0, 31));
    t.pc = {$urandom, $urandom};
    t.r1 = {$urandom, $urandom};
    t.r2 = ($urandom_range(0, 3) == 0) ? t.r1 : {$urandom, $urandom};
    t.imm = {$urandom, $urandom};
    t.aluop = 2'($urandom_range(0, 2));
    t.f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: t.f7 = 7'b0000000;
      1: t.f7 = 7'b0100000;
      default: t.f7 = 7'($urandom_range(0, 127));
    endcase
    if (allow_mul && $urandom_range(0, 15) == 0) begin
      t.aluop = 2'b10; t.f3 = 3'b000; t.f7 = 7'b0000001;
    end
    if (!allow_mul && is_mul(t)) t.f7 = 7'b0000000;
    return t;
  endfunction

  function automatic instr_t base_instr();
    instr_t t;
    t = '0;
    t.rw = 1'b1;
    t.wr = 5'd7;
    return t;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(rand_instr(1'b0));
      push_entry(1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
      next_cycle();
    end
    reset = 1'b0;
    last_alu = '0; last_reg2 = '0; last_tgt = '0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%016h expected 0x%016h", name, $time, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    logic stall_s;
    forever begin
      @(negedge clk);
      stall_s = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (e[204]) chk("stall", {63'd0, stall_s}, {63'd0, e[203]});
        if (e[202]) chk("wr_reg", {59'd0, exmemWrReg}, {59'd0, e[201:197]});
        chk("reg_write", {63'd0, exmemRegWrite}, {63'd0, e[196]});
        chk("mem_to_reg", {63'd0, exmemMemToReg}, {63'd0, e[195]});
        chk("mem_read", {63'd0, exmemMemRead}, {63'd0, e[194]});
        chk("mem_write", {63'd0, exmemMemWrite}, {63'd0, e[193]});
        chk("br_taken", {63'd0, exmemBrTaken}, {63'd0, e[192]});
        chk("br_target", exmemBrTarget, e[191:128]);
        chk("reg2", exmemReg2, e[127:64]);
        chk("alu_res", exmemAluRes, e[63:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t t;
    reset = 1'b1;
    drive(base_instr());
    last_alu = '0; last_reg2 = '0; last_tgt = '0;
    next_cycle();
    do_reset(2);

    t = base_instr(); t.r1 = 64'h10; t.r2 = 64'h3; t.aluop = 2'b10;
    issue_with(t, 64'h13);
    t.f7 = 7'b0100000;
    issue_with(t, 64'hD);
    t.r1 = 64'h8000_0000_0000_0000; t.r2 = 64'd4; t.f3 = 3'b101;
    issue_with(t, 64'hF800_0000_0000_0000);

    t = base_instr(); t.rw = 1'b0; t.branch = 1'b1; t.aluop = 2'b01;
    t.r1 = 64'd5; t.r2 = 64'd5; t.pc = 64'h100; t.imm = 64'h20;
    issue_with(t, 64'd0);
    t.r2 = 64'd6;
    issue_with(t, 64'hFFFF_FFFF_FFFF_FFFF);

    t = base_instr(); t.alusrc = 1'b1; t.mr = 1'b1; t.m2r = 1'b1;
    t.r1 = 64'h1000; t.imm = 64'hFFFF_FFFF_FFFF_FFF8; t.r2 = 64'h55;
    issue_with(t, 64'hFF8);

    t = base_instr(); t.aluop = 2'b10; t.f7 = 7'b0000001; t.r1 = 64'd7; t.r2 = 64'd6;
    issue_with(t, MUL_EN ? 64'd42 : 64'd13);
    t.r1 = 64'hFFFF_FFFF_FFFF_FFFF; t.r2 = 64'd2;
    issue_with(t, MUL_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd1);
    t.r1 = 64'd123456789; t.r2 = 64'd1;
    issue(t);
    t.r1 = 64'hDEAD_BEEF; t.r2 = 64'd0;
    issue(t);

`ifdef EX_MUL_EN
    t = base_instr(); t.aluop = 2'b10; t.f7 = 7'b0000001; t.r1 = 64'd9; t.r2 = 64'd9;
    drive(t);
    for (int i = 0; i < 31; i++) begin
      push_bubble();
      next_cycle();
    end
    reset = 1'b1;
    push_entry(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    next_cycle();
    reset = 1'b0;
    last_alu = '0; last_reg2 = '0; last_tgt = '0;
    t = base_instr(); t.r1 = 64'd40; t.r2 = 64'd2;
    issue_with(t, 64'd42);
`endif

    for (int i = 0; i < 150; i++) begin
      issue(rand_instr(1'b1));
    end

    do_reset(2);
    issue(rand_instr(1'b0));

    next_cycle();
    next_cycle();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
